adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arb_pkg.sv | 13 +
 rtl/adder_arb_rr.sv | 31 +++
 rtl/adder_arbiter.sv | 100 ++++++++++
 tb/tb_adder_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the two-requester adder arbiter.
// Saturating overflow is selected by defining ADDER_ARB_SAT_EN.
package adder_arb_pkg;

  localparam int unsigned ADDER_ARB_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/adder_arb_rr.sv
// Two-way round-robin grant with a last-grant pointer that only moves on accept.
module adder_arb_rr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // 1 means requester 1 won last, so requester 0 wins the next tie.
  logic last_q;

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Arbitrated adder: accepts one operand pair in IDLE, adds in CALC, holds the result in HOLD.
// Define ADDER_ARB_SAT_EN to saturate res_sum to all ones on overflow.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_ARB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_id
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             res_id_q;

  logic [1:0]       grant;
  logic             accept;
  logic [WIDTH:0]   full_sum;
  logic [WIDTH-1:0] sum_next;

  adder_arb_rr u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  // Ready is gated by rst_n so it stays low for the whole reset window.
  always_comb begin
    req0_ready = rst_n && (state_q == IDLE) && grant[0];
    req1_ready = rst_n && (state_q == IDLE) && grant[1];
    accept     = req0_ready || req1_ready;
  end

  assign full_sum = {1'b0, a_q} + {1'b0, b_q};

`ifdef ADDER_ARB_SAT_EN
  assign sum_next = full_sum[WIDTH] ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];
`else
  assign sum_next = full_sum[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    state_d = HOLD;
      HOLD:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      res_id_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q  <= grant[1] ? req1_a : req0_a;
        b_q  <= grant[1] ? req1_b : req0_b;
        id_q <= grant[1];
      end
      // Result registers only change in CALC, so they are frozen throughout HOLD.
      if (state_q == CALC) begin
        sum_q    <= sum_next;
        carry_q  <= full_sum[WIDTH];
        res_id_q <= id_q;
      end
    end
  end

  assign res_valid = (state_q == HOLD);
  assign res_sum   = sum_q;
  assign res_carry = carry_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a transaction-level reference model and per-cycle checks.
module tb_adder_arbiter;

  localparam int W = 4;
`ifdef ADDER_ARB_SAT_EN
  localparam int OVF_SUM = 15;
`else
  localparam int OVF_SUM = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         res_valid, res_ready;
  logic [W-1:0] res_sum;
  logic         res_carry, res_id;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int sum;
    int carry;
    int id;
  } res_t;
  res_t got[$];

  adder_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_carry  (res_carry),
    .res_id     (res_id)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, aged in cycles since its accept edge.
  bit m_known = 0;
  bit m_busy  = 0;
  bit m_last  = 1;
  bit m_zero  = 0;
  int m_age   = 0;
  int e_sum, e_carry, e_id;

  function automatic int pick_id(input bit v0, input bit v1, input bit last);
    if (v0 && v1) return last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic add_model(input int a, input int b, output int s, output int c);
    int full;
    full = a + b;
    c = (full >= (1 << W)) ? 1 : 0;
    if (c == 0) s = full;
`ifdef ADDER_ARB_SAT_EN
    else s = (1 << W) - 1;
`else
    else s = full - (1 << W);
`endif
  endtask

  always begin
    int pid;
    bit exp_valid;
    @(negedge clk);
    #2;
    if (m_known) begin
      pid = (rst_n && !m_busy) ? pick_id(req0_valid, req1_valid, m_last) : -1;
      exp_valid = m_busy && (m_age >= 2);
      chk("req0_ready", 32'(req0_ready), (pid == 0) ? 1 : 0);
      chk("req1_ready", 32'(req1_ready), (pid == 1) ? 1 : 0);
      chk("res_valid", 32'(res_valid), exp_valid ? 1 : 0);
      if (exp_valid) begin
        chk("res_sum", 32'(res_sum), e_sum);
        chk("res_carry", 32'(res_carry), e_carry);
        chk("res_id", 32'(res_id), e_id);
      end else if (m_zero) begin
        chk("res_sum_rst", 32'(res_sum), 0);
        chk("res_carry_rst", 32'(res_carry), 0);
        chk("res_id_rst", 32'(res_id), 0);
      end
      if (res_valid === 1'b1 && res_ready === 1'b1)
        got.push_back('{sum: int'(res_sum), carry: int'(res_carry), id: int'(res_id)});
    end
    @(posedge clk);
    if (!rst_n) begin
      m_known = 1;
      m_busy  = 0;
      m_last  = 1;
      m_zero  = 1;
      m_age   = 0;
    end else if (m_known) begin
      if (!m_busy) begin
        pid = pick_id(req0_valid, req1_valid, m_last);
        if (pid == 0) add_model(int'(req0_a), int'(req0_b), e_sum, e_carry);
        if (pid == 1) add_model(int'(req1_a), int'(req1_b), e_sum, e_carry);
        if (pid >= 0) begin
          m_busy = 1;
          m_age  = 1;
          m_last = pid[0];
          e_id   = pid;
        end
      end else if (m_age >= 2 && res_ready) begin
        m_busy = 0;
      end else begin
        m_age++;
        if (m_age >= 2) m_zero = 0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int exp_sum[10]   = '{2, 7, OVF_SUM, 5, 9, 5, 9, 11, 2, 4};
    int exp_carry[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    int exp_id[10]    = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 1};
    int n;

    // Reset held 3 cycles with both requesters valid.
    rst_n = 0; res_ready = 1;
    req0_valid = 1; req0_a = 1; req0_b = 1;
    req1_valid = 1; req1_a = 5; req1_b = 6;
    cycles(3);
    rst_n = 1;
    cycles(1);
    req0_valid = 0; req1_valid = 0;
    cycles(4);

    // Single requester.
    req0_valid = 1; req0_a = 3; req0_b = 4;
    cycles(1);
    req0_valid = 0;
    cycles(4);

    // Overflow via req1.
    req1_valid = 1; req1_a = 9; req1_b = 8;
    cycles(1);
    req1_valid = 0;
    cycles(4);

    // Contention: both valid for four full transactions.
    req0_valid = 1; req0_a = 2; req0_b = 3;
    req1_valid = 1; req1_a = 4; req1_b = 5;
    cycles(12);
    req0_valid = 0; req1_valid = 0;
    cycles(4);

    // Backpressure: result held while req1 waits.
    res_ready = 0;
    req0_valid = 1; req0_a = 6; req0_b = 5;
    cycles(1);
    req0_valid = 0;
    req1_valid = 1; req1_a = 1; req1_b = 1;
    cycles(7);
    res_ready = 1;
    cycles(2);
    req1_valid = 0;
    cycles(4);

    // Reset while in CALC discards the operation.
    req0_valid = 1; req0_a = 7; req0_b = 7;
    cycles(1);
    req0_valid = 0; rst_n = 0;
    cycles(1);
    rst_n = 1;
    cycles(3);
    req1_valid = 1; req1_a = 2; req1_b = 2;
    cycles(1);
    req1_valid = 0;
    cycles(4);

    chk("result_count", 32'(got.size()), 10);
    n = (got.size() < 10) ? got.size() : 10;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("lit_sum[%0d]", i), 32'(got[i].sum), exp_sum[i]);
      chk($sformatf("lit_carry[%0d]", i), 32'(got[i].carry), exp_carry[i]);
      chk($sformatf("lit_id[%0d]", i), 32'(got[i].id), exp_id[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
